mesh_resp_writeback: RTL and testbench
======================================

// Module: mesh_resp_writeback
// PURPOSE
//  Consumes the mesh's per-row response stream (valid-only, no backpressure) and turns it into
//  scratchpad/accumulator row-write requests with lane masks. Also emits one ROB completion per tile.
//  Sits directly downstream of the mesh-with-delays stage, ahead of the spad/acc write arbiter.
//  A small FIFO absorbs write-port stalls. Rows are dropped and flagged only on overflow.
// PARAMETERS
//  DIM        16  mesh width; lanes per row
//  ACC_W      20  width of each response lane (signed)
//  SP_W       8   scratchpad element width (signed) after saturation
//  ADDR_W     14  local row address width
//  ROB_W      6   ROB id width
//  DEPTH      4   FIFO entries (power of two, >=2)
// PORTS
//  clk                                 in   1         clock
//  rst                                 in   1         async reset, ACTIVE-LOW (0 = reset)
//  in_payload_discriminant             in   1         response row valid
//  in_payload_Some_0_tag_rob_id_discriminant / _Some_0   in  1 / ROB_W   tile ROB id valid / id
//  in_payload_Some_0_tag_addr_is_acc_addr / _accumulate / _is_garbage   in  1 each   addr flags
//  in_payload_Some_0_tag_addr_data     in   ADDR_W    tile base row address
//  in_payload_Some_0_tag_rows / _tag_cols   in  5 each   valid rows / cols of tile (1..DIM)
//  in_payload_Some_0_last              in   1         last row of tile
//  in_payload_Some_0_data              in   DIM*ACC_W lane j at [j*ACC_W +: ACC_W]
//  out_write_payload_discriminant      out  1         write request valid
//  out_write_payload_Some_0_is_acc / _accumulate   out  1 each   target acc / accumulate-on-write
//  out_write_payload_Some_0_addr       out  ADDR_W    row address
//  out_write_payload_Some_0_data       out  DIM*ACC_W lane data (spad: saturated, sign-extended)
//  out_write_payload_Some_0_mask       out  DIM       lane j enabled iff j < tag_cols
//  out_write_resolver_ready            in   1         write port accepts
//  out_done_payload_discriminant / _Some_0   out  1 / ROB_W   1-cycle completion pulse / ROB id
//  overflow_err                        out  1         sticky: row arrived with FIFO full and no pop
//  fifo_count                          out  log2(DEPTH)+1   occupancy
// BEHAVIOUR
//  Reset: FIFO empty, row counter 0, all outputs 0 (write/done valid low, overflow_err 0).
//  Reset mid-tile discards all queued rows and any pending completion.
//  Row counter cnt (5b): increments on every valid input row, garbage rows included.
//   It clears to 0 on a row with last=1. Write addr = tag_addr_data + cnt, mod 2^ADDR_W.
//  Classify each valid row:
//   WRITE: is_garbage=0 and cnt < tag_rows. Push a full entry.
//   DONE-ONLY: not WRITE, last=1 and rob_id valid. Push an entry with write disabled.
//   DROP: otherwise. Nothing is pushed.
//  Spad target (is_acc=0): each lane saturates to [-128,127], then sign-extends to ACC_W.
//  Acc target: data passes unchanged. Mask = (1<<tag_cols)-1; tag_cols>=DIM gives all ones.
//  Latency: input row at cycle t is visible at the FIFO head at t+1 at the earliest (registered).
//  Write handshake: the head WRITE entry pops when valid & ready. Data, addr and mask stay stable
//   while valid & !ready. A DONE-ONLY head pops unconditionally, with out_write valid low.
//  Completion: out_done pulses with rob_id in the cycle the tile's last entry pops.
//   This applies when that entry has last=1, rob_id valid, and either is a WRITE with handshake
//   or is DONE-ONLY. Completions never reorder with writes.
//  Full FIFO + push + pop in the same cycle: the push succeeds (pop frees the slot combinationally).
//  Full FIFO + push, no pop: the row is lost and overflow_err is set (sticky until reset).
//   cnt still advances. Upstream must schedule to keep this impossible; the bench checks it.
//  Empty FIFO + push: no bypass; the entry appears next cycle. Pointers wrap modulo DEPTH.
// STRUCTURE
//  gemmini_pkg: DIM, ACC_W, SP_W, ADDR_W, ROB_W; resp_tag_t, wb_entry_t {write_en, is_acc,
//   accumulate, addr, data, mask, last, rob_valid, rob_id}; function sat_sp().
//  One sub-module, wb_fifo (DEPTH x wb_entry_t, count output, simultaneous push/pop).
//  The top holds the row counter, classify/saturate/mask logic, and head decode.
// TESTING
//  1 Acc tile, rows=4 cols=16 base=0x100 rob=5, ready=1: writes 0x100..0x103 in order, mask
//    0xFFFF, data unchanged, done(5) in the cycle row 3 pops.
//  2 Spad tile with lanes +300,-300,127,-129: written lanes 127,-128,127,-128; cols=3 gives
//    mask 0x0007.
//  3 16 rows sent, rows=2, last on row 15, rob=9: exactly 2 writes, DONE-ONLY entry, done(9)
//    with out_write valid low.
//  4 Garbage tile, 16 rows, rob valid=0: no writes, no done, cnt back to 0, next tile starts
//    at its base.
//  5 ready held 0 for 4 rows then released: fifo_count reaches 4, head stable while stalled.
//    5th row arriving with a pop in the same cycle is kept; without a pop, overflow_err=1.
//  6 rst driven 0 with 3 entries queued mid-tile: outputs 0 immediately, fifo_count=0.
//    No done for that tile after release.

Source files
------------

// File: rtl/mesh_resp_writeback_pkg.sv
// rtl/mesh_resp_writeback_pkg.sv - shared parameters, tag/entry types and spad saturation helper
package mesh_resp_writeback_pkg;

    localparam int DIM    = 16;
    localparam int ACC_W  = 20;
    localparam int SP_W   = 8;
    localparam int ADDR_W = 14;
    localparam int ROB_W  = 6;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              rob_valid;
        logic [ROB_W-1:0]  rob_id;
        logic              is_acc;
        logic              accumulate;
        logic              is_garbage;
        logic [ADDR_W-1:0] addr;
        logic [4:0]        rows;
        logic [4:0]        cols;
    } resp_tag_t;

    typedef struct packed {
        logic                 write_en;
        logic                 is_acc;
        logic                 accumulate;
        logic [ADDR_W-1:0]    addr;
        logic [DIM*ACC_W-1:0] data;
        logic [DIM-1:0]       mask;
        logic                 last;
        logic                 rob_valid;
        logic [ROB_W-1:0]     rob_id;
    } wb_entry_t;

    // Clamp one accumulator lane to the signed SP_W range, result sign-extended to ACC_W.
    function automatic logic [ACC_W-1:0] sat_sp(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = ACC_W'((1 << (SP_W - 1)) - 1);
        lo = ACC_W'(-(1 << (SP_W - 1)));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/mesh_resp_writeback_if.sv
// rtl/mesh_resp_writeback_if.sv - mesh response input, write request output and completion bundle
interface mesh_resp_writeback_if;
    import mesh_resp_writeback_pkg::*;

    logic                 in_payload_discriminant;
    logic                 in_payload_Some_0_tag_rob_id_discriminant;
    logic [ROB_W-1:0]     in_payload_Some_0_tag_rob_id_Some_0;
    logic                 in_payload_Some_0_tag_addr_is_acc_addr;
    logic                 in_payload_Some_0_tag_addr_accumulate;
    logic                 in_payload_Some_0_tag_addr_is_garbage;
    logic [ADDR_W-1:0]    in_payload_Some_0_tag_addr_data;
    logic [4:0]           in_payload_Some_0_tag_rows;
    logic [4:0]           in_payload_Some_0_tag_cols;
    logic                 in_payload_Some_0_last;
    logic [DIM*ACC_W-1:0] in_payload_Some_0_data;

    logic                 out_write_payload_discriminant;
    logic                 out_write_payload_Some_0_is_acc;
    logic                 out_write_payload_Some_0_accumulate;
    logic [ADDR_W-1:0]    out_write_payload_Some_0_addr;
    logic [DIM*ACC_W-1:0] out_write_payload_Some_0_data;
    logic [DIM-1:0]       out_write_payload_Some_0_mask;
    logic                 out_write_resolver_ready;

    logic                 out_done_payload_discriminant;
    logic [ROB_W-1:0]     out_done_payload_Some_0;

    modport master (
        output in_payload_discriminant, in_payload_Some_0_tag_rob_id_discriminant,
               in_payload_Some_0_tag_rob_id_Some_0, in_payload_Some_0_tag_addr_is_acc_addr,
               in_payload_Some_0_tag_addr_accumulate, in_payload_Some_0_tag_addr_is_garbage,
               in_payload_Some_0_tag_addr_data, in_payload_Some_0_tag_rows,
               in_payload_Some_0_tag_cols, in_payload_Some_0_last, in_payload_Some_0_data,
               out_write_resolver_ready,
        input  out_write_payload_discriminant, out_write_payload_Some_0_is_acc,
               out_write_payload_Some_0_accumulate, out_write_payload_Some_0_addr,
               out_write_payload_Some_0_data, out_write_payload_Some_0_mask,
               out_done_payload_discriminant, out_done_payload_Some_0
    );

    modport slave (
        input  in_payload_discriminant, in_payload_Some_0_tag_rob_id_discriminant,
               in_payload_Some_0_tag_rob_id_Some_0, in_payload_Some_0_tag_addr_is_acc_addr,
               in_payload_Some_0_tag_addr_accumulate, in_payload_Some_0_tag_addr_is_garbage,
               in_payload_Some_0_tag_addr_data, in_payload_Some_0_tag_rows,
               in_payload_Some_0_tag_cols, in_payload_Some_0_last, in_payload_Some_0_data,
               out_write_resolver_ready,
        output out_write_payload_discriminant, out_write_payload_Some_0_is_acc,
               out_write_payload_Some_0_accumulate, out_write_payload_Some_0_addr,
               out_write_payload_Some_0_data, out_write_payload_Some_0_mask,
               out_done_payload_discriminant, out_done_payload_Some_0
    );

endinterface

// File: rtl/mesh_resp_writeback_fifo.sv
// rtl/mesh_resp_writeback_fifo.sv - DEPTH-entry writeback FIFO with same-cycle push/pop and overflow flag
module wb_fifo
    import mesh_resp_writeback_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_entry_t        push_data,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(pop);
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mesh_resp_writeback.sv
// rtl/mesh_resp_writeback.sv - mesh row responses to masked spad/acc row writes plus ROB completions
module mesh_resp_writeback
    import mesh_resp_writeback_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mesh_resp_writeback_if.slave  io,
    output logic                  overflow_err,
    output logic [CNT_W-1:0]      fifo_count
);

    resp_tag_t        tag;
    wb_entry_t        entry;
    wb_entry_t        head;
    logic [4:0]       cnt;
    logic             row_valid;
    logic             is_write;
    logic             done_only;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic             write_valid;
    logic             done;
    logic [ACC_W-1:0] lane;

    assign row_valid = io.in_payload_discriminant;
    assign tag = '{rob_valid:  io.in_payload_Some_0_tag_rob_id_discriminant,
                   rob_id:     io.in_payload_Some_0_tag_rob_id_Some_0,
                   is_acc:     io.in_payload_Some_0_tag_addr_is_acc_addr,
                   accumulate: io.in_payload_Some_0_tag_addr_accumulate,
                   is_garbage: io.in_payload_Some_0_tag_addr_is_garbage,
                   addr:       io.in_payload_Some_0_tag_addr_data,
                   rows:       io.in_payload_Some_0_tag_rows,
                   cols:       io.in_payload_Some_0_tag_cols};

    // Garbage and dropped rows still advance the row index so addresses stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (row_valid)
            cnt <= io.in_payload_Some_0_last ? 5'd0 : cnt + 5'd1;
    end

    always_comb begin
        is_write  = !tag.is_garbage && (cnt < tag.rows);
        done_only = !is_write && io.in_payload_Some_0_last && tag.rob_valid;
        push      = row_valid && (is_write || done_only);

        entry            = '0;
        entry.write_en   = is_write;
        entry.is_acc     = tag.is_acc;
        entry.accumulate = tag.accumulate;
        entry.addr       = tag.addr + ADDR_W'(cnt);
        entry.last       = io.in_payload_Some_0_last;
        entry.rob_valid  = tag.rob_valid;
        entry.rob_id     = tag.rob_id;
        lane             = '0;
        for (int j = 0; j < DIM; j++) begin
            lane = io.in_payload_Some_0_data[j*ACC_W +: ACC_W];
            entry.data[j*ACC_W +: ACC_W] = tag.is_acc ? lane : sat_sp(lane);
            entry.mask[j] = (5'(j) < tag.cols);
        end
    end

    wb_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .overflow  (overflow_err)
    );

    // Done-only heads drain without waiting on the write port.
    assign head_valid  = (fifo_count != '0);
    assign write_valid = head_valid && head.write_en;
    assign pop         = head_valid && (!head.write_en || io.out_write_resolver_ready);
    assign done        = pop && head.last && head.rob_valid;

    assign io.out_write_payload_discriminant      = write_valid;
    assign io.out_write_payload_Some_0_is_acc     = write_valid && head.is_acc;
    assign io.out_write_payload_Some_0_accumulate = write_valid && head.accumulate;
    assign io.out_write_payload_Some_0_addr       = write_valid ? head.addr : '0;
    assign io.out_write_payload_Some_0_data       = write_valid ? head.data : '0;
    assign io.out_write_payload_Some_0_mask       = write_valid ? head.mask : '0;
    assign io.out_done_payload_discriminant       = done;
    assign io.out_done_payload_Some_0             = done ? head.rob_id : '0;

endmodule

// File: tb/tb_mesh_resp_writeback.sv
// tb/tb_mesh_resp_writeback.sv - directed self-checking bench for mesh_resp_writeback
module tb_mesh_resp_writeback;
    import mesh_resp_writeback_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             overflow_err;
    logic [CNT_W-1:0] fifo_count;
    int               n_cmp = 0;
    int               n_fail = 0;

    mesh_resp_writeback_if io();

    mesh_resp_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .io           (io),
        .overflow_err (overflow_err),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    logic [ADDR_W-1:0]    wq_addr [$];
    logic [DIM*ACC_W-1:0] wq_data [$];
    logic [DIM-1:0]       wq_mask [$];
    logic [1:0]           wq_flag [$];
    logic [ROB_W-1:0]     dq_id   [$];
    logic                 dq_ww   [$];
    logic [ADDR_W-1:0]    dq_addr [$];

    always @(negedge clk) begin
        if (io.out_write_payload_discriminant && io.out_write_resolver_ready) begin
            wq_addr.push_back(io.out_write_payload_Some_0_addr);
            wq_data.push_back(io.out_write_payload_Some_0_data);
            wq_mask.push_back(io.out_write_payload_Some_0_mask);
            wq_flag.push_back({io.out_write_payload_Some_0_is_acc, io.out_write_payload_Some_0_accumulate});
        end
        if (io.out_done_payload_discriminant) begin
            dq_id.push_back(io.out_done_payload_Some_0);
            dq_ww.push_back(io.out_write_payload_discriminant);
            dq_addr.push_back(io.out_write_payload_Some_0_addr);
        end
    end

    function automatic logic [DIM*ACC_W-1:0] ramp(input int r);
        logic [DIM*ACC_W-1:0] v;
        v = '0;
        for (int j = 0; j < DIM; j++)
            v[j*ACC_W +: ACC_W] = ACC_W'(r * 32 + j);
        return v;
    endfunction

    task automatic set_tile(input logic rv, input logic [ROB_W-1:0] rid, input logic acc,
                            input logic accum, input logic garb, input logic [ADDR_W-1:0] base,
                            input logic [4:0] rows, input logic [4:0] cols);
        io.in_payload_Some_0_tag_rob_id_discriminant = rv;
        io.in_payload_Some_0_tag_rob_id_Some_0       = rid;
        io.in_payload_Some_0_tag_addr_is_acc_addr    = acc;
        io.in_payload_Some_0_tag_addr_accumulate     = accum;
        io.in_payload_Some_0_tag_addr_is_garbage     = garb;
        io.in_payload_Some_0_tag_addr_data           = base;
        io.in_payload_Some_0_tag_rows                = rows;
        io.in_payload_Some_0_tag_cols                = cols;
    endtask

    task automatic send_row(input logic last, input logic [DIM*ACC_W-1:0] d, input logic rdy);
        @(posedge clk);
        #1;
        io.in_payload_discriminant  = 1'b1;
        io.in_payload_Some_0_last   = last;
        io.in_payload_Some_0_data   = d;
        io.out_write_resolver_ready = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) begin
            @(posedge clk);
            #1;
            io.in_payload_discriminant  = 1'b0;
            io.in_payload_Some_0_last   = 1'b0;
            io.out_write_resolver_ready = rdy;
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (io.out_write_payload_discriminant !== 1'b0 || io.out_done_payload_discriminant !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got write=%b done=%b want 0 0", io.out_write_payload_discriminant, io.out_done_payload_discriminant);
        end
        n_cmp++;
        if (fifo_count !== '0 || overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got count=%0d ovf=%b want 0 0", fifo_count, overflow_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_acc_tile();
        int w0 = wq_addr.size();
        int d0 = dq_id.size();
        set_tile(1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 14'h100, 5'd4, 5'd16);
        for (int i = 0; i < 4; i++)
            send_row(i == 3, ramp(i), 1'b1);
        idle(4, 1'b1);
        n_cmp++;
        if (wq_addr.size() - w0 !== 4) begin
            n_fail++;
            $display("FAIL acc_write_count: got %0d want 4", wq_addr.size() - w0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (wq_addr[w0+i] !== 14'h100 + 14'(i) || wq_mask[w0+i] !== 16'hFFFF || wq_flag[w0+i] !== 2'b11) begin
                    n_fail++;
                    $display("FAIL acc_write_%0d: got addr=%h mask=%h flags=%b want %h ffff 11", i, wq_addr[w0+i], wq_mask[w0+i], wq_flag[w0+i], 14'h100 + 14'(i));
                end
                n_cmp++;
                if (wq_data[w0+i] !== ramp(i)) begin
                    n_fail++;
                    $display("FAIL acc_data_%0d: got %h want %h", i, wq_data[w0+i], ramp(i));
                end
            end
        end
        n_cmp++;
        if (dq_id.size() - d0 !== 1) begin
            n_fail++;
            $display("FAIL acc_done_count: got %0d want 1", dq_id.size() - d0);
        end else begin
            n_cmp++;
            if (dq_id[d0] !== 6'd5 || dq_ww[d0] !== 1'b1 || dq_addr[d0] !== 14'h103) begin
                n_fail++;
                $display("FAIL acc_done: got id=%0d with_write=%b addr=%h want 5 1 103", dq_id[d0], dq_ww[d0], dq_addr[d0]);
            end
        end
    endtask

    task automatic test_spad_saturate();
        int w0 = wq_addr.size();
        int d0 = dq_id.size();
        logic [DIM*ACC_W-1:0] din = '0;
        logic [DIM*ACC_W-1:0] exp = '0;
        din[0*ACC_W +: ACC_W] = ACC_W'(300);
        din[1*ACC_W +: ACC_W] = ACC_W'(-300);
        din[2*ACC_W +: ACC_W] = ACC_W'(127);
        din[3*ACC_W +: ACC_W] = ACC_W'(-129);
        exp[0*ACC_W +: ACC_W] = 20'h0007F;
        exp[1*ACC_W +: ACC_W] = 20'hFFF80;
        exp[2*ACC_W +: ACC_W] = 20'h0007F;
        exp[3*ACC_W +: ACC_W] = 20'hFFF80;
        set_tile(1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 14'h040, 5'd1, 5'd3);
        send_row(1'b1, din, 1'b1);
        idle(3, 1'b1);
        n_cmp++;
        if (wq_addr.size() - w0 !== 1) begin
            n_fail++;
            $display("FAIL spad_write_count: got %0d want 1", wq_addr.size() - w0);
        end else begin
            n_cmp++;
            if (wq_data[w0] !== exp) begin
                n_fail++;
                $display("FAIL spad_data: got %h want %h", wq_data[w0], exp);
            end
            n_cmp++;
            if (wq_mask[w0] !== 16'h0007 || wq_addr[w0] !== 14'h040 || wq_flag[w0] !== 2'b00) begin
                n_fail++;
                $display("FAIL spad_mask_addr: got mask=%h addr=%h flags=%b want 0007 040 00", wq_mask[w0], wq_addr[w0], wq_flag[w0]);
            end
        end
        n_cmp++;
        if (dq_id.size() - d0 !== 1 || dq_id[d0] !== 6'd2) begin
            n_fail++;
            $display("FAIL spad_done: got count=%0d want 1 with id 2", dq_id.size() - d0);
        end
    endtask

    task automatic test_done_only();
        int w0 = wq_addr.size();
        int d0 = dq_id.size();
        set_tile(1'b1, 6'd9, 1'b1, 1'b0, 1'b0, 14'h200, 5'd2, 5'd16);
        for (int i = 0; i < 16; i++)
            send_row(i == 15, ramp(i), 1'b1);
        idle(4, 1'b1);
        n_cmp++;
        if (wq_addr.size() - w0 !== 2) begin
            n_fail++;
            $display("FAIL donly_write_count: got %0d want 2", wq_addr.size() - w0);
        end else begin
            n_cmp++;
            if (wq_addr[w0] !== 14'h200 || wq_addr[w0+1] !== 14'h201) begin
                n_fail++;
                $display("FAIL donly_addrs: got %h %h want 200 201", wq_addr[w0], wq_addr[w0+1]);
            end
        end
        n_cmp++;
        if (dq_id.size() - d0 !== 1) begin
            n_fail++;
            $display("FAIL donly_done_count: got %0d want 1", dq_id.size() - d0);
        end else begin
            n_cmp++;
            if (dq_id[d0] !== 6'd9 || dq_ww[d0] !== 1'b0) begin
                n_fail++;
                $display("FAIL donly_done: got id=%0d with_write=%b want 9 0", dq_id[d0], dq_ww[d0]);
            end
        end
    endtask

    task automatic test_garbage();
        int w0 = wq_addr.size();
        int d0 = dq_id.size();
        set_tile(1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 14'h280, 5'd16, 5'd16);
        for (int i = 0; i < 16; i++)
            send_row(i == 15, ramp(i), 1'b1);
        idle(3, 1'b1);
        n_cmp++;
        if (wq_addr.size() != w0 || dq_id.size() != d0 || fifo_count !== '0) begin
            n_fail++;
            $display("FAIL garbage_silent: got writes=%0d dones=%0d count=%0d want 0 0 0", wq_addr.size() - w0, dq_id.size() - d0, fifo_count);
        end
        set_tile(1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 14'h300, 5'd1, 5'd16);
        send_row(1'b1, ramp(1), 1'b1);
        idle(3, 1'b1);
        n_cmp++;
        if (wq_addr.size() - w0 !== 1 || wq_addr[w0] !== 14'h300) begin
            n_fail++;
            $display("FAIL garbage_next_base: got writes=%0d want 1 at 300", wq_addr.size() - w0);
        end
        n_cmp++;
        if (dq_id.size() - d0 !== 1 || dq_id[d0] !== 6'd3) begin
            n_fail++;
            $display("FAIL garbage_next_done: got dones=%0d want 1 id 3", dq_id.size() - d0);
        end
    endtask

    task automatic test_backpressure();
        int w0 = wq_addr.size();
        int d0 = dq_id.size();
        int exp_rows [7] = '{0, 1, 2, 3, 4, 6, 7};
        set_tile(1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 14'h400, 5'd8, 5'd16);
        for (int i = 0; i < 4; i++)
            send_row(1'b0, ramp(i), 1'b0);
        idle(1, 1'b0);
        n_cmp++;
        if (fifo_count !== CNT_W'(4) || io.out_write_payload_discriminant !== 1'b1 || io.out_write_payload_Some_0_addr !== 14'h400) begin
            n_fail++;
            $display("FAIL bp_full: got count=%0d valid=%b addr=%h want 4 1 400", fifo_count, io.out_write_payload_discriminant, io.out_write_payload_Some_0_addr);
        end
        idle(1, 1'b0);
        n_cmp++;
        if (io.out_write_payload_Some_0_addr !== 14'h400 || io.out_write_payload_Some_0_data !== ramp(0) || io.out_write_payload_Some_0_mask !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL bp_stable: got addr=%h mask=%h want 400 ffff", io.out_write_payload_Some_0_addr, io.out_write_payload_Some_0_mask);
        end
        send_row(1'b0, ramp(4), 1'b1);
        send_row(1'b0, ramp(5), 1'b0);
        n_cmp++;
        if (overflow_err !== 1'b0 || fifo_count !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL bp_push_pop_kept: got ovf=%b count=%0d want 0 4", overflow_err, fifo_count);
        end
        send_row(1'b0, ramp(6), 1'b1);
        n_cmp++;
        if (overflow_err !== 1'b1 || fifo_count !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL bp_overflow: got ovf=%b count=%0d want 1 4", overflow_err, fifo_count);
        end
        send_row(1'b1, ramp(7), 1'b1);
        idle(8, 1'b1);
        n_cmp++;
        if (wq_addr.size() - w0 !== 7) begin
            n_fail++;
            $display("FAIL bp_write_count: got %0d want 7", wq_addr.size() - w0);
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (wq_addr[w0+i] !== 14'h400 + 14'(exp_rows[i]) || wq_data[w0+i] !== ramp(exp_rows[i])) begin
                    n_fail++;
                    $display("FAIL bp_write_%0d: got addr=%h want %h", i, wq_addr[w0+i], 14'h400 + 14'(exp_rows[i]));
                end
            end
        end
        n_cmp++;
        if (dq_id.size() - d0 !== 1 || dq_id[d0] !== 6'd7 || dq_addr[d0] !== 14'h407 || fifo_count !== '0) begin
            n_fail++;
            $display("FAIL bp_done: got dones=%0d count=%0d want 1 id 7 at 407, count 0", dq_id.size() - d0, fifo_count);
        end
    endtask

    task automatic test_reset_mid_tile();
        int w0;
        int d0;
        set_tile(1'b1, 6'd11, 1'b1, 1'b0, 1'b0, 14'h500, 5'd4, 5'd16);
        for (int i = 0; i < 3; i++)
            send_row(1'b0, ramp(i), 1'b0);
        idle(1, 1'b0);
        n_cmp++;
        if (fifo_count !== CNT_W'(3)) begin
            n_fail++;
            $display("FAIL rst_pre_count: got %0d want 3", fifo_count);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (fifo_count !== '0 || overflow_err !== 1'b0 || io.out_write_payload_discriminant !== 1'b0 ||
            io.out_write_payload_Some_0_addr !== '0 || io.out_done_payload_discriminant !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got count=%0d ovf=%b valid=%b addr=%h want 0 0 0 0", fifo_count, overflow_err, io.out_write_payload_discriminant, io.out_write_payload_Some_0_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        w0 = wq_addr.size();
        d0 = dq_id.size();
        idle(6, 1'b1);
        n_cmp++;
        if (wq_addr.size() != w0 || dq_id.size() != d0) begin
            n_fail++;
            $display("FAIL rst_no_stale: got writes=%0d dones=%0d want 0 0", wq_addr.size() - w0, dq_id.size() - d0);
        end
        set_tile(1'b1, 6'd12, 1'b1, 1'b0, 1'b0, 14'h600, 5'd1, 5'd16);
        send_row(1'b1, ramp(9), 1'b1);
        idle(3, 1'b1);
        n_cmp++;
        if (wq_addr.size() - w0 !== 1 || wq_addr[w0] !== 14'h600 || dq_id.size() - d0 !== 1 || dq_id[d0] !== 6'd12) begin
            n_fail++;
            $display("FAIL rst_next_tile: got writes=%0d dones=%0d want 1 at 600, done 12", wq_addr.size() - w0, dq_id.size() - d0);
        end
    endtask

    initial begin
        io.in_payload_discriminant  = 1'b0;
        io.in_payload_Some_0_last   = 1'b0;
        io.in_payload_Some_0_data   = '0;
        io.out_write_resolver_ready = 1'b0;
        set_tile(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 14'h0, 5'd0, 5'd0);
        test_reset();
        test_acc_tile();
        test_spad_saturate();
        test_done_only();
        test_garbage();
        test_backpressure();
        test_reset_mid_tile();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
